// File: rtl/pip_vertex_feeder.sv
// Polygon vertex buffer and replay stage in front of the PIP core.
// Optional WAIT timeout: define PIP_FEEDER_TIMEOUT_EN.
module pip_vertex_feeder #(
  parameter int WIDTH   = 16,
  parameter int POINTS  = 5,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             v_valid,
  output logic             v_ready,
  input  logic [WIDTH-1:0] v_x,
  input  logic [WIDTH-1:0] v_y,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [WIDTH-1:0] q_x,
  input  logic [WIDTH-1:0] q_y,
  output logic             pip_en,
  output logic [WIDTH-1:0] pip_xc,
  output logic [WIDTH-1:0] pip_yc,
  output logic [WIDTH-1:0] pip_xi,
  output logic [WIDTH-1:0] pip_yi,
  input  logic             pip_fin,
  input  logic [WIDTH-1:0] pip_res,
  output logic             r_valid,
  input  logic             r_ready,
  output logic [WIDTH-1:0] r_data,
  output logic             r_err
);

  localparam int CW = $clog2(POINTS + 1);
  localparam logic [CW-1:0] LAST = CW'(POINTS - 1);
  localparam logic [CW-1:0] KMAX = CW'(POINTS);

  if (POINTS < 3 || TIMEOUT < 1) begin : g_cfg_bad
    $error("pip_vertex_feeder: POINTS must be >=3, TIMEOUT >=1");
  end

  typedef enum logic [2:0] {
    S_LOAD, S_IDLE, S_STREAM, S_WAIT, S_RESULT
  } state_t;

  state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [CW-1:0] k, k_n;
  logic [WIDTH-1:0] vx [POINTS];
  logic [WIDTH-1:0] vy [POINTS];

  logic v_ready_n, q_ready_n, pip_en_n, r_valid_n;
  logic [WIDTH-1:0] xc_n, yc_n, xi_n, yi_n, r_data_n;

`ifdef PIP_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tcnt, tcnt_n;
  logic err_n;
`endif

  // Next-state and next-output decode; clear overrides everything.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    k_n       = k;
    v_ready_n = v_ready;
    q_ready_n = q_ready;
    pip_en_n  = pip_en;
    xc_n      = pip_xc;
    yc_n      = pip_yc;
    xi_n      = pip_xi;
    yi_n      = pip_yi;
    r_valid_n = r_valid;
    r_data_n  = r_data;
`ifdef PIP_FEEDER_TIMEOUT_EN
    tcnt_n    = tcnt;
    err_n     = r_err;
`endif
    unique case (state)
      S_LOAD: begin
        if (v_valid && v_ready) begin
          cnt_n = cnt + 1'b1;
          if (cnt == LAST) begin
            cnt_n     = '0;
            v_ready_n = 1'b0;
            q_ready_n = 1'b1;
            state_n   = S_IDLE;
          end
        end
      end
      S_IDLE: begin
        if (q_valid && q_ready) begin
          xc_n      = q_x;
          yc_n      = q_y;
          xi_n      = '0;
          yi_n      = '0;
          k_n       = '0;
          pip_en_n  = 1'b1;
          q_ready_n = 1'b0;
          state_n   = S_STREAM;
        end
      end
      S_STREAM: begin
        if (k == KMAX) begin
          pip_en_n = 1'b0;
          xi_n     = '0;
          yi_n     = '0;
          k_n      = '0;
          state_n  = S_WAIT;
`ifdef PIP_FEEDER_TIMEOUT_EN
          tcnt_n   = '0;
`endif
        end else begin
          k_n  = k + 1'b1;
          xi_n = vx[k];
          yi_n = vy[k];
        end
      end
      S_WAIT: begin
        if (pip_fin) begin
          r_data_n  = pip_res;
          r_valid_n = 1'b1;
          state_n   = S_RESULT;
`ifdef PIP_FEEDER_TIMEOUT_EN
        end else if (tcnt == TLAST) begin
          r_data_n  = '0;
          r_valid_n = 1'b1;
          err_n     = 1'b1;
          state_n   = S_RESULT;
        end else begin
          tcnt_n = tcnt + 1'b1;
`endif
        end
      end
      S_RESULT: begin
        if (r_ready) begin
          r_valid_n = 1'b0;
          q_ready_n = 1'b1;
          state_n   = S_IDLE;
`ifdef PIP_FEEDER_TIMEOUT_EN
          err_n     = 1'b0;
`endif
        end
      end
      default: state_n = S_LOAD;
    endcase
    if (clear) begin
      state_n   = S_LOAD;
      cnt_n     = '0;
      k_n       = '0;
      v_ready_n = 1'b1;
      q_ready_n = 1'b0;
      pip_en_n  = 1'b0;
      xi_n      = '0;
      yi_n      = '0;
      r_valid_n = 1'b0;
`ifdef PIP_FEEDER_TIMEOUT_EN
      err_n     = 1'b0;
`endif
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_LOAD;
      cnt     <= '0;
      k       <= '0;
      v_ready <= 1'b1;
      q_ready <= 1'b0;
      pip_en  <= 1'b0;
      pip_xc  <= '0;
      pip_yc  <= '0;
      pip_xi  <= '0;
      pip_yi  <= '0;
      r_valid <= 1'b0;
      r_data  <= '0;
`ifdef PIP_FEEDER_TIMEOUT_EN
      tcnt    <= '0;
      r_err   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      k       <= k_n;
      v_ready <= v_ready_n;
      q_ready <= q_ready_n;
      pip_en  <= pip_en_n;
      pip_xc  <= xc_n;
      pip_yc  <= yc_n;
      pip_xi  <= xi_n;
      pip_yi  <= yi_n;
      r_valid <= r_valid_n;
      r_data  <= r_data_n;
`ifdef PIP_FEEDER_TIMEOUT_EN
      tcnt    <= tcnt_n;
      r_err   <= err_n;
`endif
    end
  end

`ifndef PIP_FEEDER_TIMEOUT_EN
  assign r_err = 1'b0;
`endif

  // Vertex buffer write; contents need no reset.
  always_ff @(posedge clk) begin
    if (!rst && !clear && state == S_LOAD && v_valid) begin
      vx[cnt] <= v_x;
      vy[cnt] <= v_y;
    end
  end

endmodule
